uart_tx_arbiter: RTL and testbench

Round-robin arbiter that shares the single uart transmitter between `N_REQ` byte-stream requesters, for example the command sequencer, the status reporter and the debug echo path. It drives the uart `send`/`to_send` inputs and sequences each byte against `tx_done`. It locks the grant for the duration of a multi-byte packet and recovers from a stalled transmitter with a watchdog. It sits between the requesters and `uart` in the top level.

---
 rtl/uart_ctrl_pkg.sv | 9 +
 rtl/uart_tx_arbiter_rr_pick.sv | 25 ++
 rtl/uart_tx_arbiter.sv | 92 +++++++++
 tb/tb_uart_tx_arbiter.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_ctrl_pkg.sv
// uart_ctrl_pkg: shared state type, limits and index helper for the uart control blocks
package uart_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, START, WAIT_BUSY, WAIT_DONE} arb_state_t;
  localparam int DEFAULT_TIMEOUT = 4096;
  localparam int MAX_REQ = 8;
  function automatic int rr_wrap(input int i, input int n);
    return i >= n ? i - n : i;
  endfunction
endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rr_pick: first request at or after the pointer, or only the owner while a lock is held
module rr_pick
  import uart_ctrl_pkg::*;
#(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          lock,
  input  logic [IW-1:0] owner,
  output logic [IW-1:0] idx,
  output logic          valid
);
  // Scanning from the far end lets the nearest candidate to the pointer win.
  always_comb begin
    idx = owner;
    valid = lock && req[owner];
    for (int k = MAX_REQ - 1; k >= 0; k--)
      if (!lock && k < N && req[IW'(rr_wrap(int'(ptr) + k, N))]) begin
        idx = IW'(rr_wrap(int'(ptr) + k, N));
        valid = 1'b1;
      end
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin share of one uart transmitter among N_REQ byte streams,
// with a packet lock and a per-phase watchdog against a stalled transmitter.
module uart_tx_arbiter
  import uart_ctrl_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ-1:0]   req_last,
  input  logic [8*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]   grant,
  output logic               send,
  output logic [7:0]         to_send,
  input  logic               tx_done,
  output logic               busy,
  output logic               locked,
  output logic               timeout_err
);
  localparam int IW = $clog2(N_REQ);
  localparam int CW = $clog2(TIMEOUT + 1);
  arb_state_t    r_state, w_next;
  logic [IW-1:0] r_ptr, r_owner, r_win, w_idx, w_win_inc;
  logic          r_lock, r_last, r_err, w_valid, w_to, w_sat;
  logic [CW-1:0] r_cnt;
  logic [7:0]    r_to_send;

  rr_pick #(.N(N_REQ)) u_pick (
    .req  (req),
    .ptr  (r_ptr),
    .lock (r_lock),
    .owner(r_owner),
    .idx  (w_idx),
    .valid(w_valid)
  );

  assign w_sat = r_cnt == CW'(TIMEOUT);
  assign w_to = w_sat && (r_state == WAIT_BUSY || r_state == WAIT_DONE);
  assign w_win_inc = IW'(rr_wrap(int'(r_win) + 1, N_REQ));

  // Watchdog expiry wins over a transmitter edge arriving in the same cycle.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:      w_next = w_valid ? START : IDLE;
      START:     w_next = WAIT_BUSY;
      WAIT_BUSY: w_next = w_to ? IDLE : tx_done ? WAIT_BUSY : WAIT_DONE;
      WAIT_DONE: w_next = (w_to || tx_done) ? IDLE : WAIT_DONE;
      default:   w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_ptr <= '0;
      r_owner <= '0;
      r_win <= '0;
      r_lock <= 1'b0;
      r_last <= 1'b0;
      r_err <= 1'b0;
      r_cnt <= '0;
      r_to_send <= '0;
    end else begin
      r_state <= w_next;
      r_err <= w_to;
      r_cnt <= (w_next != r_state) ? '0 : w_sat ? r_cnt : r_cnt + CW'(1);
      if (r_state == IDLE && w_valid) begin
        r_win <= w_idx;
        r_last <= req_last[w_idx];
        r_to_send <= 8'(req_data >> {w_idx, 3'b000});
      end
      if (w_to) begin
        r_lock <= 1'b0;
        r_ptr <= w_win_inc;
      end else if (r_state == WAIT_DONE && tx_done) begin
        r_lock <= !r_last;
        r_owner <= r_win;
        if (r_last) r_ptr <= w_win_inc;
      end
    end
  end

  assign grant = (r_state == START) ? N_REQ'(1) << r_win : '0;
  assign send = r_state == START || r_state == WAIT_BUSY;
  assign busy = r_state != IDLE;
  assign locked = r_lock;
  assign timeout_err = r_err;
  assign to_send = r_to_send;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed and randomized byte streams against a queue-based arbitration model
module tb_uart_tx_arbiter;
  localparam int NR = 4;
  localparam int TO = 16;
  logic clk = 1'b0, reset = 1'b1, tx_done = 1'b1;
  logic [NR-1:0] req = '0, req_last = '0, grant;
  logic [8*NR-1:0] req_data = '0;
  logic send, busy, locked, timeout_err;
  logic [7:0] to_send;
  int n_cmp = 0, n_err = 0;
  bit [8:0] q[NR][$];
  bit hold_off[NR];
  int ptr = 0, owner = 0;
  bit lock = 1'b0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.N_REQ(NR), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .req(req), .req_last(req_last), .req_data(req_data),
    .grant(grant), .send(send), .to_send(to_send), .tx_done(tx_done),
    .busy(busy), .locked(locked), .timeout_err(timeout_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NR-1:0] cur_req();
    cur_req = '0;
    for (int i = 0; i < NR; i++) cur_req[i] = q[i].size() > 0 && !hold_off[i];
  endfunction

  task automatic apply();
    req = cur_req();
    for (int i = 0; i < NR; i++) begin
      req_last[i] = q[i].size() > 0 ? q[i][0][8] : 1'b0;
      req_data[8*i +: 8] = q[i].size() > 0 ? q[i][0][7:0] : 8'h00;
    end
  endtask

  task automatic push(input int r, input bit l, input logic [7:0] d);
    q[r].push_back({l, d});
    apply();
  endtask

  function automatic int pick();
    logic [NR-1:0] r = cur_req();
    if (lock) return r[owner] ? owner : -1;
    for (int k = 0; k < NR; k++) if (r[(ptr + k) % NR]) return (ptr + k) % NR;
    return -1;
  endfunction

  // mode 0: normal handshake, 1: tx_done stuck high, 2: tx_done stuck low after start
  task automatic xfer(input int mode, input int hi, input int lo);
    int w;
    bit cl;
    step();
    chk("err_clear", timeout_err, 0);
    w = pick();
    if (w < 0) begin
      chk("grant_none", grant, 0);
      chk("busy_none", busy, 0);
      chk("lock_hold", locked, lock);
      return;
    end
    chk("grant", grant, 1 << w);
    chk("send_start", send, 1);
    chk("to_send", to_send, q[w][0][7:0]);
    chk("locked_start", locked, lock);
    cl = q[w][0][8];
    void'(q[w].pop_front());
    apply();
    if (mode == 0) begin
      for (int c = 0; c < hi; c++) begin
        step();
        chk("send_hold", send, 1);
        chk("grant_pulse", grant, 0);
      end
      tx_done = 1'b0;
      step();
      chk("send_drop", send, 0);
      chk("busy_tx", busy, 1);
      for (int c = 0; c < lo; c++) begin
        step();
        chk("busy_tx", busy, 1);
      end
      tx_done = 1'b1;
      step();
      if (cl) begin
        lock = 1'b0;
        ptr = (w + 1) % NR;
      end else begin
        lock = 1'b1;
        owner = w;
      end
      chk("busy_idle", busy, 0);
      chk("locked_end", locked, lock);
    end else begin
      if (mode == 2) begin
        step();
        chk("send_hold", send, 1);
        tx_done = 1'b0;
      end
      for (int n = 1; n <= TO + 2; n++) begin
        step();
        chk("wdog_err", timeout_err, n == TO + 2);
        chk("wdog_send", send, mode == 1 && n < TO + 2);
        chk("wdog_busy", busy, n < TO + 2);
      end
      tx_done = 1'b1;
      lock = 1'b0;
      ptr = (w + 1) % NR;
      chk("wdog_lock", locked, 0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int r, len, md;
    step();
    step();
    chk("rst_grant", grant, 0);
    chk("rst_send", send, 0);
    chk("rst_to_send", to_send, 0);
    chk("rst_busy", busy, 0);
    chk("rst_locked", locked, 0);
    chk("rst_err", timeout_err, 0);
    reset = 1'b0;
    // round robin 0,1,2,3,0
    push(0, 1, 8'h10);
    push(0, 1, 8'h10);
    push(1, 1, 8'h20);
    push(2, 1, 8'h30);
    push(3, 1, 8'h40);
    repeat (5) xfer(0, 2, 1);
    // single bytes
    push(0, 1, 8'h41);
    xfer(0, 2, 1);
    push(1, 1, 8'h5a);
    xfer(0, 1, 0);
    // packet lock with a competing requester
    push(2, 0, 8'ha1);
    push(2, 0, 8'ha2);
    push(2, 1, 8'ha3);
    push(1, 1, 8'hb1);
    repeat (4) xfer(0, 3, 2);
    // owner withdraws mid-packet
    push(3, 0, 8'hc1);
    push(3, 1, 8'hc2);
    push(0, 1, 8'hd1);
    xfer(0, 1, 1);
    hold_off[3] = 1'b1;
    apply();
    repeat (3) xfer(0, 1, 1);
    hold_off[3] = 1'b0;
    apply();
    repeat (2) xfer(0, 2, 0);
    // watchdog in both phases, including while locked
    push(1, 0, 8'he1);
    push(1, 0, 8'he2);
    push(1, 1, 8'he3);
    push(2, 1, 8'hf1);
    xfer(0, 1, 1);
    xfer(1, 0, 0);
    xfer(0, 2, 2);
    xfer(0, 2, 2);
    push(3, 1, 8'h99);
    xfer(2, 0, 0);
    // randomized streams
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 2) == 0 || cur_req() == '0) begin
        r = $urandom_range(0, NR - 1);
        len = $urandom_range(1, 3);
        for (int b = 0; b < len; b++) push(r, b == len - 1, 8'($urandom_range(0, 255)));
      end
      md = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 2) : 0;
      xfer(md, $urandom_range(1, 4), $urandom_range(0, 3));
    end
    for (int it = 0; it < 60 && cur_req() != '0; it++) xfer(0, 1, 0);
    // async reset in WAIT_DONE while locked
    push(2, 0, 8'h77);
    push(2, 1, 8'h78);
    xfer(0, 1, 1);
    step();
    chk("rst_pre_grant", grant, 4'b0100);
    void'(q[2].pop_front());
    apply();
    step();
    tx_done = 1'b0;
    step();
    chk("rst_pre_send", send, 0);
    #2 reset = 1'b1;
    #1;
    chk("arst_send", send, 0);
    chk("arst_grant", grant, 0);
    chk("arst_busy", busy, 0);
    chk("arst_locked", locked, 0);
    chk("arst_to_send", to_send, 0);
    chk("arst_err", timeout_err, 0);
    q[2].delete();
    lock = 1'b0;
    ptr = 0;
    tx_done = 1'b1;
    apply();
    step();
    step();
    reset = 1'b0;
    push(3, 1, 8'h66);
    push(0, 1, 8'h55);
    xfer(0, 2, 1);
    xfer(0, 2, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
